// File: rtl/fir_serial_mac.sv
// fir_serial_mac: single-multiplier sequential FIR stage.
// A sample is shifted into a TAPS-deep delay line. The block then spends TAPS
// cycles accumulating c[k]*x[k] with one multiply per cycle. The finished sum
// is held in a registered output until the downstream side accepts it.
module fir_serial_mac #(
   parameter int DW   = 8,
   parameter int CW   = 8,
   parameter int TAPS = 8,
   parameter int AW   = DW + CW + $clog2(TAPS)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic signed [DW-1:0]      in_data,
   input  logic                      coef_we,
   input  logic [$clog2(TAPS)-1:0]   coef_addr,
   input  logic signed [CW-1:0]      coef_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic signed [AW-1:0]      out_data,
   output logic                      busy
);

   localparam int IW = $clog2(TAPS);
   localparam int PW = DW + CW;

   typedef enum logic [1:0] {S_IDLE, S_MAC, S_DONE} state_t;

   state_t                state_q;
   logic signed [DW-1:0]  x_q [TAPS];
   logic signed [CW-1:0]  c_q [TAPS];
   logic signed [AW-1:0]  acc_q;
   logic signed [AW-1:0]  acc_d;
   logic signed [AW-1:0]  out_data_q;
   logic [IW-1:0]         idx_q;
   logic                  out_valid_q;
   logic                  in_ready_q;
   logic                  busy_q;

   logic                  accept;
   logic                  coef_wr_en;
   logic signed [PW-1:0]  prod;

   // A sample is taken only while idle; coefficient writes are locked out
   // otherwise so a result in flight always sees one consistent coefficient set.
   assign accept     = (state_q == S_IDLE) && in_valid;
   assign coef_wr_en = (state_q == S_IDLE) && coef_we;

   // Full-precision signed product of the currently selected tap, sign-extended
   // into the accumulator width (AW is wide enough that no overflow can occur).
   assign prod  = x_q[idx_q] * c_q[idx_q];
   assign acc_d = acc_q + {{(AW-PW){prod[PW-1]}}, prod};

   // Delay line: shifts one position per accepted sample, holds otherwise.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < TAPS; k++) x_q[k] <= '0;
      end else if (accept) begin
         x_q[0] <= in_data;
         for (int k = 1; k < TAPS; k++) x_q[k] <= x_q[k-1];
      end
   end

   // Coefficient register file, written only while idle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < TAPS; k++) c_q[k] <= '0;
      end else if (coef_wr_en) begin
         c_q[coef_addr] <= coef_data;
      end
   end

   // Control FSM with accumulator, tap index and registered handshake outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         acc_q       <= '0;
         idx_q       <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  acc_q      <= '0;
                  idx_q      <= '0;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
                  state_q    <= S_MAC;
               end
            end
            S_MAC: begin
               acc_q <= acc_d;
               idx_q <= idx_q + 1'b1;
               if (idx_q == IW'(TAPS - 1)) begin
                  out_data_q  <= acc_d;
                  out_valid_q <= 1'b1;
                  state_q     <= S_DONE;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  busy_q      <= 1'b0;
                  state_q     <= S_IDLE;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               busy_q      <= 1'b0;
               state_q     <= S_IDLE;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_fir_serial_mac.sv
// Directed testbench for fir_serial_mac with hand-computed expected results.
module tb_fir_serial_mac;

   localparam int DW   = 8;
   localparam int CW   = 8;
   localparam int TAPS = 8;
   localparam int AW   = 19;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic                  in_valid = 1'b0;
   logic                  in_ready;
   logic signed [DW-1:0]  in_data = '0;
   logic                  coef_we = 1'b0;
   logic [2:0]            coef_addr = '0;
   logic signed [CW-1:0]  coef_data = '0;
   logic                  out_valid;
   logic                  out_ready = 1'b1;
   logic signed [AW-1:0]  out_data;
   logic                  busy;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   fir_serial_mac #(.DW(DW), .CW(CW), .TAPS(TAPS)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .coef_we   (coef_we),
      .coef_addr (coef_addr),
      .coef_data (coef_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy)
   );

   task automatic check(input string tag, input longint obs, input longint exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end else begin
         $display("ok   %s: %0d", tag, obs);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_coef(input int k, input int v);
      coef_we   = 1'b1;
      coef_addr = 3'(k);
      coef_data = CW'(v);
      tick();
      coef_we   = 1'b0;
   endtask

   // Present a sample and return just after the edge that accepts it.
   task automatic accept(input int v);
      int n = 0;
      in_valid = 1'b1;
      in_data  = DW'(v);
      while (in_ready !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      if (n >= 20) check("accept_timeout", in_ready, 1);
      tick();
      in_valid = 1'b0;
   endtask

   // Count edges until out_valid, check latency and value, then drain if allowed.
   task automatic wait_result(input string tag, input longint exp, input int lat);
      int cnt = 0;
      while (out_valid !== 1'b1 && cnt < 20) begin
         tick();
         cnt++;
      end
      check({tag, "_lat"}, cnt, lat);
      check(tag, out_data, exp);
      if (out_ready) tick();
   endtask

   task automatic do_reset();
      #3 rst = 1'b0;
      tick();
      tick();
      rst = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int imp_exp [8] = '{1, 2, 3, 4, 5, 6, 7, 8};
      int neg_exp [8] = '{16384, 32768, 49152, 65536, 81920, 98304, 114688, 131072};
      logic saw;

      // 1. Asynchronous reset clears outputs immediately
      #2 rst = 1'b0;
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_busy", busy, 0);
      tick();
      tick();
      rst = 1'b1;
      #1;
      check("rel_in_ready", in_ready, 1);
      check("rel_busy", busy, 0);

      // 2. Impulse response with c[k] = k+1
      for (int k = 0; k < TAPS; k++) write_coef(k, k + 1);
      for (int n = 0; n < TAPS; n++) begin
         accept(n == 0 ? 1 : 0);
         if (n == 0) check("imp_busy", busy, 1);
         wait_result($sformatf("imp_%0d", n), imp_exp[n], 8);
      end

      // 3. Signed extremes
      for (int k = 0; k < TAPS; k++) write_coef(k, -128);
      for (int n = 0; n < TAPS; n++) begin
         accept(-128);
         wait_result($sformatf("neg_%0d", n), neg_exp[n], 8);
      end
      do_reset();
      for (int k = 0; k < TAPS; k++) write_coef(k, -128);
      accept(127);
      wait_result("pos127", -16256, 8);

      // 4. Backpressure in DONE
      out_ready = 1'b0;
      accept(1);
      wait_result("bp", -16384, 8);
      in_valid = 1'b1;
      in_data  = 8'sd5;
      for (int i = 0; i < 5; i++) begin
         tick();
         check($sformatf("bp_hold_data_%0d", i), out_data, -16384);
         check($sformatf("bp_hold_valid_%0d", i), out_valid, 1);
         check($sformatf("bp_hold_rdy_%0d", i), in_ready, 0);
      end
      out_ready = 1'b1;
      tick();
      check("bp_rel_valid", out_valid, 0);
      check("bp_rel_in_ready", in_ready, 1);
      tick();
      check("bp_acc_busy", busy, 1);
      check("bp_acc_in_ready", in_ready, 0);
      in_valid = 1'b0;
      wait_result("bp_next", -17024, 8);

      // 5. Coefficient lockout during MAC
      accept(2);
      tick();
      tick();
      coef_we   = 1'b1;
      coef_addr = 3'd0;
      coef_data = 8'sd50;
      tick();
      coef_we   = 1'b0;
      wait_result("lock_mac", -17280, 5);
      write_coef(0, 50);
      accept(3);
      wait_result("lock_idle", -17130, 8);

      // 6. Reset mid-MAC at idx=4, then simultaneous coef write and sample
      accept(3);
      for (int i = 0; i < 4; i++) tick();
      #3 rst = 1'b0;
      #1;
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_data", out_data, 0);
      check("mid_rst_busy", busy, 0);
      saw = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (out_valid) saw = 1'b1;
         if (i == 1) rst = 1'b1;
      end
      check("mid_rst_no_valid", saw, 0);
      coef_we   = 1'b1;
      coef_addr = 3'd0;
      coef_data = 8'sd3;
      in_valid  = 1'b1;
      in_data   = 8'sd1;
      tick();
      coef_we  = 1'b0;
      in_valid = 1'b0;
      wait_result("simul_wr", 3, 8);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fir_serial_mac.md
Name: fir_serial_mac

Overview:
Single-multiplier sequential FIR stage: accepts one input sample at a time, shifts it into a TAPS-deep delay line of load-enabled sample registers, then computes y = sum c[k]*x[k] over TAPS cycles, one MAC per cycle. It sits directly upstream of the output holding register bank (load-enabled flip-flops). out_valid/out_data drive that bank's ld/D inputs. Coefficients are held in a local register file written through a simple write port.

Parameters:
DW, 8, sample width (signed two's complement)
CW, 8, coefficient width (signed two's complement)
TAPS, 8, number of taps, power of two, >=2
AW, DW+CW+$clog2(TAPS) (19 at defaults), accumulator/output width

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-low reset; clears all state immediately
in_valid  in  1  upstream sample available
in_ready  out  1  block can accept a sample (high only in IDLE)
in_data  in  DW  signed input sample
coef_we  in  1  coefficient write strobe
coef_addr  in  $clog2(TAPS)  coefficient index k
coef_data  in  CW  signed coefficient value
out_valid  out  1  out_data holds a finished result
out_ready  in  1  downstream consumed result
out_data  out  AW  signed filter output, registered
busy  out  1  high in MAC or DONE

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; delay line x[0..TAPS-1]=0; coefficients c[0..TAPS-1]=0; acc=0; tap index=0; out_data=0; out_valid=0; busy=0; in_ready=1 once rst deasserts.
- States: IDLE, MAC, DONE.
- IDLE: in_ready=1. On edge with in_valid=1: x[0]<=in_data, x[k]<=x[k-1] for k=1..TAPS-1; acc<=0; idx<=0; go to MAC. With in_valid=0: delay line holds.
- MAC: in_ready=0. Each edge: acc<=acc+sext(x[idx])*sext(c[idx]), idx<=idx+1. On the edge where idx==TAPS-1: the final product is added; out_data<=final sum; out_valid<=1; go to DONE.
- Latency: out_valid rises TAPS edges after the accepting edge (8 at defaults).
- DONE: out_valid=1. out_data and out_valid stay stable until an edge with out_ready=1; that edge clears out_valid and returns to IDLE. out_data keeps its last value after that.
- Throughput: one sample per TAPS+2 cycles when out_ready is held high.
- Arithmetic: full-precision signed multiply (DW+CW bits), sign-extended into the AW-bit accumulator. No saturation or rounding. AW guarantees no overflow for any inputs.
- Coefficient writes: c[coef_addr]<=coef_data on an edge with coef_we=1, only in IDLE. Ignored in MAC and DONE, so the result in flight uses a consistent coefficient set.
- Simultaneous coef_we and in_valid in IDLE: both take effect on the same edge. That sample's computation uses the newly written coefficient.
- in_valid during MAC/DONE is not accepted (in_ready=0). Upstream must hold in_data until acceptance.
- Reset mid-operation: computation abandoned, all state cleared as above. No out_valid pulse is produced.

Test Plan:
1. Reset check: hold rst=0 mid-cycle -> out_valid=0, out_data=0, busy=0 immediately. After release: in_ready=1.
2. Impulse response: write c[k]=k+1 (k=0..7); feed 1 then seven 0s with out_ready=1 -> outputs 1,2,3,4,5,6,7,8. Each out_valid occurs 8 edges after its accepting edge.
3. Signed extremes: all c=-128; feed -128 eight times -> eighth output = 131072. Feed 127 with c=-128 after a reset -> first output = -16256.
4. Backpressure: hold out_ready=0 for 5 cycles in DONE with in_valid=1 -> out_data stable, in_ready=0, no sample accepted. Raise out_ready -> IDLE next edge, sample accepted on the following edge.
5. Coefficient lockout: during MAC write c[0]=50 -> ignored, result unchanged. Repeat the write in IDLE -> next result reflects c[0]=50.
6. Reset mid-MAC: assert rst at idx=4 -> no out_valid. After release, delay line is all zero: impulse input 1 with c[0]=3 gives output 3.
